drum_onset_detect: RTL and testbench



---
 rtl/drum_pkg.sv | 23 ++
 rtl/drum_band_classify.sv | 30 +++
 rtl/drum_onset_detect.sv | 169 ++++++++++++++++
 tb/tb_drum_onset_detect.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// -----------------------------------------------------------------------------
// drum_pkg
// Shared definitions for the drum onset detector and its helpers:
//   - FREQ_W / AMP_W : widths of the spectral peak frequency and amplitude
//   - drum_e         : drum voice reported with each hit
//   - ARMED / HOLDOFF / REARM : onset FSM state encodings
// -----------------------------------------------------------------------------
package drum_pkg;

  localparam int FREQ_W = 13;
  localparam int AMP_W  = 10;

  typedef enum logic [1:0] {
    DRUM_KICK  = 2'd0,
    DRUM_SNARE = 2'd1,
    DRUM_HIHAT = 2'd2
  } drum_e;

  localparam logic [1:0] ARMED   = 2'd0;
  localparam logic [1:0] HOLDOFF = 2'd1;
  localparam logic [1:0] REARM   = 2'd2;

endpackage

// File: rtl/drum_band_classify.sv
// -----------------------------------------------------------------------------
// drum_band_classify
// Combinational frequency -> drum voice map. Kept separate so display logic
// can reuse exactly the same band edges as the detector.
// Ports:
//   freq_i : peak frequency (bin x 4)
//   drum_o : KICK below KICK_MAX_FREQ, SNARE below SNARE_MAX_FREQ, else HIHAT
// -----------------------------------------------------------------------------
module drum_band_classify
  import drum_pkg::*;
#(
  parameter logic [FREQ_W-1:0] KICK_MAX_FREQ  = 13'd400,
  parameter logic [FREQ_W-1:0] SNARE_MAX_FREQ = 13'd1600
) (
  input  logic [FREQ_W-1:0] freq_i,
  output drum_e             drum_o
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else can leave it unassigned and infer a latch.
  always_comb begin
    drum_o = DRUM_HIHAT;
    if (freq_i < KICK_MAX_FREQ) begin
      drum_o = DRUM_KICK;
    end else if (freq_i < SNARE_MAX_FREQ) begin
      drum_o = DRUM_SNARE;
    end
  end

endmodule

// File: rtl/drum_onset_detect.sv
// -----------------------------------------------------------------------------
// drum_onset_detect
// Samples the per-frame FFT spectral peak, detects drum onsets with threshold,
// rise and hysteresis rules, and emits a one-cycle hit pulse with drum voice
// and velocity for the sample-playback stage.
//
// Pipeline: stage S registers the peak on the frame_done edge, stage E
// evaluates it on the following edge, so hit is high the cycle after that.
//
// Ports:
//   clock, reset_n       : clock, synchronous active-low reset
//   frame_done           : one-cycle strobe, max_freq/max_amp valid
//   max_freq, max_amp    : spectral peak frequency (bin x 4) and amplitude
//   hit                  : one-cycle onset pulse
//   hit_drum             : 0 kick, 1 snare, 2 hihat (held between hits)
//   hit_velocity         : amplitude of the onset frame (held between hits)
//   armed                : high while the detector is in ARMED
//   hit_count            : saturating hit counter, only when the macro
//                          DRUM_ONSET_HIT_COUNT_EN is defined
// -----------------------------------------------------------------------------
module drum_onset_detect
  import drum_pkg::*;
#(
  parameter logic [AMP_W-1:0]  THRESH_ON      = 10'd200,
  parameter logic [AMP_W-1:0]  THRESH_OFF     = 10'd120,
  parameter logic [AMP_W-1:0]  RISE_MIN       = 10'd40,
  parameter logic [3:0]        HOLDOFF_FRAMES = 4'd4,
  parameter logic [FREQ_W-1:0] KICK_MAX_FREQ  = 13'd400,
  parameter logic [FREQ_W-1:0] SNARE_MAX_FREQ = 13'd1600
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              frame_done,
  input  logic [FREQ_W-1:0] max_freq,
  input  logic [AMP_W-1:0]  max_amp,
  output logic              hit,
  output logic [1:0]        hit_drum,
  output logic [AMP_W-1:0]  hit_velocity,
  output logic              armed
`ifdef DRUM_ONSET_HIT_COUNT_EN
  ,
  output logic [15:0]       hit_count
`endif
);

  // Stage S registers
  logic [FREQ_W-1:0] cur_freq_q;
  logic [AMP_W-1:0]  cur_amp_q;
  logic              sample_valid_q;

  // Stage E state
  logic [1:0]        state_q,    state_d;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic [AMP_W-1:0]  prev_amp_q, prev_amp_d;
  logic              hit_q,      hit_d;
  drum_e             hit_drum_q, hit_drum_d;
  logic [AMP_W-1:0]  hit_vel_q,  hit_vel_d;
  logic              armed_q;

  drum_e             cur_class;
  logic              onset;
  logic              below_off;
  logic [AMP_W:0]    rise_target;

  drum_band_classify #(
    .KICK_MAX_FREQ  (KICK_MAX_FREQ),
    .SNARE_MAX_FREQ (SNARE_MAX_FREQ)
  ) u_classify (
    .freq_i (cur_freq_q),
    .drum_o (cur_class)
  );

  // One extra bit so prev_amp + RISE_MIN cannot wrap and fake a rise.
  assign rise_target = {1'b0, prev_amp_q} + {1'b0, RISE_MIN};
  assign onset       = (cur_amp_q >= THRESH_ON)
                    && ({1'b0, cur_amp_q} >= rise_target)
                    && (cur_freq_q != '0);
  assign below_off   = (cur_amp_q < THRESH_OFF);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    prev_amp_d = prev_amp_q;
    hit_d      = 1'b0;
    hit_drum_d = hit_drum_q;
    hit_vel_d  = hit_vel_q;
    if (sample_valid_q) begin
      prev_amp_d = cur_amp_q;
      case (state_q)
        ARMED: begin
          if (onset) begin
            hit_d      = 1'b1;
            hit_drum_d = cur_class;
            hit_vel_d  = cur_amp_q;
            hold_cnt_d = HOLDOFF_FRAMES;
            state_d    = HOLDOFF;
          end
        end
        HOLDOFF: begin
          hold_cnt_d = hold_cnt_q - 4'd1;
          // Last holdoff frame: a quiet frame re-arms straight away.
          if (hold_cnt_q <= 4'd1) begin
            hold_cnt_d = '0;
            state_d    = below_off ? ARMED : REARM;
          end
        end
        REARM: begin
          if (below_off) begin
            state_d = ARMED;
          end
        end
        default: state_d = ARMED;
      endcase
    end
  end

  // NOTE: the stage-S peak registers carry no reset; they are only consumed
  // when sample_valid_q is set, and that flag itself is reset.
  always_ff @(posedge clock) begin
    if (frame_done) begin
      cur_freq_q <= max_freq;
      cur_amp_q  <= max_amp;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sample_valid_q <= 1'b0;
      state_q        <= ARMED;
      hold_cnt_q     <= '0;
      prev_amp_q     <= '0;
      hit_q          <= 1'b0;
      hit_drum_q     <= DRUM_KICK;
      hit_vel_q      <= '0;
      armed_q        <= 1'b0;
    end else begin
      sample_valid_q <= frame_done;
      state_q        <= state_d;
      hold_cnt_q     <= hold_cnt_d;
      prev_amp_q     <= prev_amp_d;
      hit_q          <= hit_d;
      hit_drum_q     <= hit_drum_d;
      hit_vel_q      <= hit_vel_d;
      armed_q        <= (state_d == ARMED);
    end
  end

  assign hit          = hit_q;
  assign hit_drum     = hit_drum_q;
  assign hit_velocity = hit_vel_q;
  assign armed        = armed_q;

`ifdef DRUM_ONSET_HIT_COUNT_EN
  logic [15:0] hit_count_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hit_count_q <= '0;
    end else if (hit_d && (hit_count_q != 16'hFFFF)) begin
      hit_count_q <= hit_count_q + 16'd1;
    end
  end

  assign hit_count = hit_count_q;
`endif

endmodule

// File: tb/tb_drum_onset_detect.sv
// -----------------------------------------------------------------------------
// tb_drum_onset_detect
// Directed bench for drum_onset_detect. A frame-level model tracks the
// detector's behaviour (holdoff frames left, waiting-for-quiet flag, previous
// amplitude) and a negedge process compares every cycle; directed steps add
// hand-computed literal expectations. Optional hit_count checks follow the
// DRUM_ONSET_HIT_COUNT_EN macro.
// -----------------------------------------------------------------------------
module tb_drum_onset_detect;
  import drum_pkg::*;

  logic        clock      = 1'b0;
  logic        reset_n    = 1'b0;
  logic        frame_done = 1'b0;
  logic [12:0] max_freq   = '0;
  logic [9:0]  max_amp    = '0;
  logic        hit;
  logic [1:0]  hit_drum;
  logic [9:0]  hit_velocity;
  logic        armed;
`ifdef DRUM_ONSET_HIT_COUNT_EN
  logic [15:0] hit_count;
`endif

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  drum_onset_detect dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .frame_done   (frame_done),
    .max_freq     (max_freq),
    .max_amp      (max_amp),
    .hit          (hit),
    .hit_drum     (hit_drum),
    .hit_velocity (hit_velocity),
    .armed        (armed)
`ifdef DRUM_ONSET_HIT_COUNT_EN
    ,
    .hit_count    (hit_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level model
  // ---------------------------------------------------------------------------
  int m_prev      = 0;
  int m_hold_left = 0;   // holdoff frames still to be ignored
  bit m_wait_quiet = 0;  // holdoff over, waiting for a quiet frame
  bit m_pend      = 0;
  int m_pf        = 0;
  int m_pa        = 0;
  bit exp_hit     = 0;
  int exp_drum    = 0;
  int exp_vel     = 0;
  bit exp_armed   = 0;
  int exp_count   = 0;

  function automatic int band(input int f);
    if (f < 400)  return 0;
    if (f < 1600) return 1;
    return 2;
  endfunction

  task automatic model_frame(input int f, input int a);
    if (m_hold_left == 0 && !m_wait_quiet) begin
      if (a >= 200 && a >= m_prev + 40 && f != 0) begin
        exp_hit     = 1;
        exp_drum    = band(f);
        exp_vel     = a;
        m_hold_left = 4;
        if (exp_count < 65535) exp_count++;
      end
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_wait_quiet = !(a < 120);
    end else if (a < 120) begin
      m_wait_quiet = 0;
    end
    m_prev = a;
  endtask

  always @(posedge clock) begin
    if (!reset_n) begin
      m_prev = 0; m_hold_left = 0; m_wait_quiet = 0; m_pend = 0;
      exp_hit = 0; exp_drum = 0; exp_vel = 0; exp_armed = 0; exp_count = 0;
    end else begin
      exp_hit = 0;
      if (m_pend) model_frame(m_pf, m_pa);
      exp_armed = (m_hold_left == 0 && !m_wait_quiet);
      m_pend = frame_done;
      m_pf   = max_freq;
      m_pa   = max_amp;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_hit", hit, exp_hit);
      check("cyc_drum", hit_drum, exp_drum);
      check("cyc_vel", hit_velocity, exp_vel);
      check("cyc_armed", armed, exp_armed);
`ifdef DRUM_ONSET_HIT_COUNT_EN
      check("cyc_count", hit_count, exp_count);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic frame(input int f, input int a);
    frame_done = 1'b1;
    max_freq   = 13'(f);
    max_amp    = 10'(a);
    @(negedge clock);
    frame_done = 1'b0;
  endtask

  // One frame, then look at hit on the cycle stage E drives it.
  task automatic frame_chk(input int f, input int a, input bit want_hit,
                           input string name);
    frame(f, a);
    @(negedge clock);
    check(name, hit, want_hit);
  endtask

  initial begin
    // Reset
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk_en = 1'b1;
    check("rst_hit", hit, 0);
    check("rst_armed", armed, 0);
    check("rst_vel", hit_velocity, 0);
    check("rst_drum", hit_drum, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_armed_next", armed, 1);

    // Basic onset: 0 then 250 at 200 Hz -> kick
    frame_chk(200, 0, 0, "t1_quiet");
    frame_chk(200, 250, 1, "t1_hit");
    check("t1_drum", hit_drum, 0);
    check("t1_vel", hit_velocity, 250);
    check("t1_armed_fall", armed, 0);

    // Holdoff ignores loud frames, then REARM until quiet
    frame_chk(200, 300, 0, "t2_hold1");
    frame_chk(200, 400, 0, "t2_hold2");
    frame_chk(200, 500, 0, "t2_hold3");
    frame_chk(200, 600, 0, "t2_hold4");
    check("t2_rearm", armed, 0);
    frame_chk(200, 100, 0, "t2_quiet");
    check("t2_armed", armed, 1);
    frame_chk(2000, 260, 1, "t2_hit");
    check("t2_drum", hit_drum, 2);
    check("t2_vel", hit_velocity, 260);

    // Quiet last holdoff frame skips REARM
    repeat (4) frame_chk(1000, 50, 0, "t3_hold");
    check("t3_direct_armed", armed, 1);
    // Slow ramp never rises by 40
    frame_chk(1000, 180, 0, "t3_ramp180");
    frame_chk(1000, 210, 0, "t3_ramp210");
    frame_chk(1000, 240, 0, "t3_ramp240");
    frame_chk(1000, 150, 0, "t3_dip150");
    frame_chk(1000, 200, 1, "t3_exact_on");
    check("t3_drum", hit_drum, 1);
    check("t3_vel", hit_velocity, 200);
    // Exactly THRESH_OFF does not re-arm
    repeat (4) frame_chk(1000, 120, 0, "t3_hold_off");
    check("t3_at_off_rearm", armed, 0);
    frame_chk(1000, 120, 0, "t3_still_rearm");
    check("t3_still_rearm_armed", armed, 0);
    frame_chk(1000, 0, 0, "t3_rearm_quiet");
    check("t3_rearmed", armed, 1);

    // DC bin never hits, but still becomes prev_amp
    frame_chk(0, 800, 0, "t4_dc");
    check("t4_dc_armed", armed, 1);
    frame_chk(500, 830, 0, "t4_prev800");
    frame_chk(500, 0, 0, "t4_zero");

    // Back-to-back strobes
    frame_done = 1'b1; max_freq = 13'd900; max_amp = 10'd0;
    @(negedge clock);
    max_amp = 10'd300;
    @(negedge clock);
    frame_done = 1'b0;
    check("t5_no_early", hit, 0);
    @(negedge clock);
    check("t5_hit", hit, 1);
    check("t5_drum", hit_drum, 1);
    check("t5_vel", hit_velocity, 300);
    @(negedge clock);
    check("t5_single", hit, 0);

    // Reset mid-holdoff; the strobe during reset is dropped
    frame_chk(900, 50, 0, "t6_hold");
    reset_n = 1'b0; frame_done = 1'b1; max_freq = 13'd900; max_amp = 10'd900;
    @(negedge clock);
    reset_n = 1'b1; frame_done = 1'b0;
    check("t6_rst_hit", hit, 0);
    check("t6_rst_vel", hit_velocity, 0);
    check("t6_rst_armed", armed, 0);
    frame_chk(300, 250, 1, "t6_hit");
    check("t6_drum", hit_drum, 0);
    check("t6_vel", hit_velocity, 250);

    // frame_done held high: one frame per cycle through the holdoff
    frame_done = 1'b1; max_freq = 13'd300; max_amp = 10'd50;
    repeat (4) @(negedge clock);
    frame_done = 1'b0;
    @(negedge clock);
    check("t7_held_armed", armed, 1);
`ifdef DRUM_ONSET_HIT_COUNT_EN
    check("t7_count", hit_count, 1);
`endif

    repeat (2) @(negedge clock);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
